register_file_sb: RTL and testbench
===================================

# register_file_sb

Parametrised successor to the RV32I integer register file. It adds configurable width and depth, N read ports and write-to-read bypass, so posedge writes are visible in the same cycle. It also keeps a per-register pending-write scoreboard for hazard detection and a sequential clear engine. It sits between decode (reads, claims) and writeback (writes) in the pipelined core.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W
- N_READ, 2, number of read ports (>=1)
- ZERO_REG, 1, 1 = address 0 hardwired to zero; 0 = address 0 is an ordinary register

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- wr_ena  in  1  writeback enable
- wr_addr  in  ADDR_W  writeback address
- wr_data  in  WIDTH  writeback data
- rd_addr  in  N_READ*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  N_READ*WIDTH  read data, port i at [i*WIDTH +: WIDTH]
- rd_busy  out  N_READ  1 = port i's register has an outstanding claimed write
- claim_ena  in  1  mark claim_addr as pending (decode issued a producer)
- claim_addr  in  ADDR_W  register being claimed
- clear_req  in  1  start zeroing all registers
- clear_busy  out  1  clear engine running
- clear_done  out  1  one-cycle pulse after the last register is cleared

## Operation
- Storage: NUM_REGS x WIDTH flops plus NUM_REGS busy bits, all with async reset to 0.
- "Writable" address: any address, except address 0 when ZERO_REG=1.
- Write: at posedge, if wr_ena and wr_addr is writable and state is IDLE, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Claim: at posedge, if claim_ena and claim_addr is writable and state is IDLE, busy[claim_addr] <= 1.
  - Claim and write to the same address in one cycle: the claim wins, busy ends at 1 and the data is written.
- Read, port i, combinational, address a = rd_addr[i]:
  - ZERO_REG=1 and a==0: rd_data=0, rd_busy=0.
  - Else if state is IDLE, wr_ena and wr_addr==a (bypass): rd_data=wr_data, rd_busy=0.
  - Else: rd_data=reg[a], rd_busy=busy[a].
- State machine IDLE / CLEAR:
  - IDLE -> CLEAR on clear_req. The counter loads the first writable address: 1 if ZERO_REG, else 0.
  - CLEAR: each cycle, reg[cnt] <= 0, busy[cnt] <= 0, cnt++.
  - On cnt == NUM_REGS-1, after that clear, go to IDLE and assert clear_done for the next cycle.
  - In CLEAR: wr_ena and claim_ena are dropped (no state change, no bypass) and clear_req is ignored.
  - Reads during CLEAR return stored values; a register being cleared this cycle still reads its old value.
- Width rules: the counter is ADDR_W bits and never wraps past NUM_REGS-1. WIDTH and ADDR_W are independent.

## Timing
- Reset values: all reg = 0, all busy = 0, state IDLE, clear_busy=0, clear_done=0. rd_data=0 and rd_busy=0 for every address.
- rst asserted mid-clear aborts immediately: IDLE, all reg and busy zero, no clear_done pulse.
- Read latency 0 (combinational). Write visible through bypass in the same cycle, and from storage the cycle after.
- Claim visible on rd_busy the cycle after the claim edge.
- clear_req sampled at edge T:
  - clear_busy=1 from T+ through the final clear edge.
  - Clear duration = NUM_REGS-ZERO_REG cycles: 31 for defaults.
  - clear_done=1 for exactly one cycle, the cycle after clear_busy falls.
  - A new clear_req in that clear_done cycle is accepted.

## Test plan
- Reset, then all 32 addresses on both ports -> rd_data=0 and rd_busy=0 everywhere. Reset asserted mid-clear -> clear_busy=0 immediately, no clear_done.
- wr_ena, addr 5, data 0xDEADBEEF, with rd_addr0=5 in the same cycle -> rd_data0=0xDEADBEEF that cycle and the next. Write 0x1234 to addr 0 -> reads 0.
- claim addr 7 -> rd_busy=1 next cycle. Write addr 7 data 42 -> rd_busy=0 and rd_data=42 in the write cycle. Simultaneous claim+write addr 9 -> rd_busy=1 afterwards, data written.
- Fill x1..x31 with 0x100+i and claim x3, then clear_req -> clear_busy for 31 cycles, clear_done one pulse. Afterwards all reads 0 and rd_busy[x3]=0. A write to x4 issued mid-clear is discarded.
- ZERO_REG=0, ADDR_W=3, WIDTH=8, N_READ=3 -> write 0xA5 to addr 0 reads back 0xA5 on all three ports. Clear lasts 8 cycles.

Source files
------------

// File: rtl/register_file_sb.sv
// Parametrised register file with write-to-read bypass, a pending-write scoreboard
// and a sequential clear engine. Sits between decode (reads, claims) and writeback.
module register_file_sb #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int N_READ   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_ena,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [N_READ*ADDR_W-1:0] rd_addr,
  output logic [N_READ*WIDTH-1:0]  rd_data,
  output logic [N_READ-1:0]        rd_busy,
  input  logic                     claim_ena,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic                     clear_req,
  output logic                     clear_busy,
  output logic                     clear_done
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam bit ZERO_EN  = (ZERO_REG != 32'sd0);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ZERO_EN ? ADDR_W'(1'b1) : {ADDR_W{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Address 0 is read-only zero when the hardwired-zero register is enabled.
  function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
    return !(ZERO_EN && (addr == {ADDR_W{1'b0}}));
  endfunction

  logic [WIDTH-1:0]    regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   cnt_r, cnt_s;
  logic                clear_done_r, done_s;
  logic                idle_s, wr_ok_s, claim_ok_s;

  assign idle_s     = (state_r == ST_IDLE);
  assign wr_ok_s    = idle_s && wr_ena && is_writable(wr_addr);
  assign claim_ok_s = idle_s && claim_ena && is_writable(claim_addr);

  // Next-state logic: the clear engine walks every writable address once.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clear_req) begin
          state_s = ST_CLEAR;
          cnt_s   = FIRST_ADDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt_r == LAST_ADDR) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + ADDR_W'(1'b1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, clear counter and done pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {ADDR_W{1'b0}};
      clear_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      clear_done_r <= done_s;
    end
  end

  // Storage and scoreboard; a claim issued with a write to the same address wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
      busy_r <= {NUM_REGS{1'b0}};
    end else if (state_r == ST_CLEAR) begin
      regs_r[cnt_r] <= {WIDTH{1'b0}};
      busy_r[cnt_r] <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        regs_r[wr_addr] <= wr_data;
        busy_r[wr_addr] <= 1'b0;
      end
      if (claim_ok_s) begin
        busy_r[claim_addr] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_READ; g++) begin : g_rd
    logic [ADDR_W-1:0] a_s;
    logic [WIDTH-1:0]  d_s;
    logic              b_s;

    assign a_s = rd_addr[g*ADDR_W +: ADDR_W];

    // Read mux: bypass is suppressed while clearing, so stored (old) values show.
    always_comb begin
      d_s = regs_r[a_s];
      b_s = busy_r[a_s];
      if (!is_writable(a_s)) begin
        d_s = {WIDTH{1'b0}};
        b_s = 1'b0;
      end else if (idle_s && wr_ena && (wr_addr == a_s)) begin
        d_s = wr_data;
        b_s = 1'b0;
      end else begin
        d_s = regs_r[a_s];
        b_s = busy_r[a_s];
      end
    end

    assign rd_data[g*WIDTH +: WIDTH] = d_s;
    assign rd_busy[g]                = b_s;
  end

  assign clear_busy = (state_r == ST_CLEAR);
  assign clear_done = clear_done_r;

endmodule

// File: tb/tb_register_file_sb.sv
// Randomised and directed bench for register_file_sb against an array-based
// reference model of the register/scoreboard/clear behaviour.
module tb_register_file_sb;

  localparam int NREGS = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wr_ena, claim_ena, clear_req;
  logic [4:0]  wr_addr, claim_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        clear_busy, clear_done;

  logic        s_wr_ena, s_claim_ena, s_clear_req;
  logic [2:0]  s_wr_addr, s_claim_addr;
  logic [7:0]  s_wr_data;
  logic [8:0]  s_rd_addr;
  logic [23:0] s_rd_data;
  logic [2:0]  s_rd_busy;
  logic        s_clear_busy, s_clear_done;

  register_file_sb dut (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .claim_ena(claim_ena), .claim_addr(claim_addr), .clear_req(clear_req),
    .clear_busy(clear_busy), .clear_done(clear_done)
  );

  register_file_sb #(.WIDTH(8), .ADDR_W(3), .N_READ(3), .ZERO_REG(0)) dut_small (
    .clk(clk), .rst(rst), .wr_ena(s_wr_ena), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .claim_ena(s_claim_ena), .claim_addr(s_claim_addr), .clear_req(s_clear_req),
    .clear_busy(s_clear_busy), .clear_done(s_clear_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: plain arrays plus a "cycles of clear left" count.
  logic [31:0] m_reg [NREGS];
  logic        m_busy[NREGS];
  int          m_clr_left;
  int          m_clr_idx;
  logic        m_done;

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_reg[i]  = 32'd0;
      m_busy[i] = 1'b0;
    end
    m_clr_left = 0;
    m_clr_idx  = 0;
    m_done     = 1'b0;
  endtask

  task automatic model_edge();
    logic done_next;
    done_next = 1'b0;
    if (m_clr_left > 0) begin
      m_reg[m_clr_idx]  = 32'd0;
      m_busy[m_clr_idx] = 1'b0;
      m_clr_idx++;
      m_clr_left--;
      if (m_clr_left == 0) done_next = 1'b1;
    end else begin
      if (clear_req) begin
        m_clr_left = NREGS - 1;
        m_clr_idx  = 1;
      end
      if (wr_ena && wr_addr != 5'd0) begin
        m_reg[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (claim_ena && claim_addr != 5'd0) m_busy[claim_addr] = 1'b1;
    end
    m_done = done_next;
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_clr_left == 0 && wr_ena && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (m_clr_left == 0 && wr_ena && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_ena = 1'b0; wr_addr = 5'd0; wr_data = 32'd0; rd_addr = 10'd0;
    claim_ena = 1'b0; claim_addr = 5'd0; clear_req = 1'b0;
    s_wr_ena = 1'b0; s_wr_addr = 3'd0; s_wr_data = 8'd0; s_rd_addr = 9'd0;
    s_claim_ena = 1'b0; s_claim_addr = 3'd0; s_clear_req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && m_clr_left > 0; k++) tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int a = 0; a < NREGS; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (rd_data[p*32 +: 32] !== 32'd0 || rd_busy[p] !== 1'b0)
          $display("FAIL reset_read addr %0d port %0d: got data %h busy %b, want 0/0",
                   a, p, rd_data[p*32 +: 32], rd_busy[p]);
        else n_pass++;
      end
    end
    n_checks++;
    if (clear_busy !== 1'b0 || clear_done !== 1'b0)
      $display("FAIL reset_clear_flags: got busy %b done %b, want 0/0", clear_busy, clear_done);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bypass();
    wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = {5'd6, 5'd5};
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0)
      $display("FAIL bypass_same_cycle: got %h/%b, want deadbeef/0", rd_data[31:0], rd_busy[0]);
    else n_pass++;
    tick();
    wr_ena = 1'b0;
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF)
      $display("FAIL bypass_next_cycle: got %h, want deadbeef", rd_data[31:0]);
    else n_pass++;
    wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rd_addr = {5'd0, 5'd0};
    #1;
    n_checks++;
    if (rd_data !== 64'd0)
      $display("FAIL zero_reg_bypass: got %h, want 0", rd_data);
    else n_pass++;
    tick();
    wr_ena = 1'b0;
    #1;
    n_checks++;
    if (rd_data !== 64'd0 || rd_busy !== 2'b00)
      $display("FAIL zero_reg_stored: got %h/%b, want 0/00", rd_data, rd_busy);
    else n_pass++;
  endtask

  task automatic test_claim();
    claim_ena = 1'b1; claim_addr = 5'd7; rd_addr = {5'd0, 5'd7};
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b0)
      $display("FAIL claim_same_cycle: got busy %b, want 0", rd_busy[0]);
    else n_pass++;
    tick();
    claim_ena = 1'b0;
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b1)
      $display("FAIL claim_next_cycle: got busy %b, want 1", rd_busy[0]);
    else n_pass++;
    wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'd42;
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'd42)
      $display("FAIL claim_then_write: got %0d/%b, want 42/0", rd_data[31:0], rd_busy[0]);
    else n_pass++;
    tick();
    wr_addr = 5'd9; wr_data = 32'h99; claim_ena = 1'b1; claim_addr = 5'd9;
    tick();
    idle_inputs();
    rd_addr = {5'd7, 5'd9};
    #1;
    n_checks++;
    if (rd_busy !== 2'b01 || rd_data[31:0] !== 32'h99 || rd_data[63:32] !== 32'd42)
      $display("FAIL claim_write_same_addr: got %h busy %b, want 0000002a00000099 busy 01",
               rd_data, rd_busy);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      wr_ena     = ($urandom_range(0, 1) == 1);
      wr_addr    = 5'($urandom_range(0, 31));
      wr_data    = $urandom;
      claim_ena  = ($urandom_range(0, 3) == 0);
      claim_addr = ($urandom_range(0, 7) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      clear_req  = ($urandom_range(0, 149) == 0);
      rd_addr[4:0] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr[9:5] = 5'($urandom_range(0, 31));
      #1;
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (rd_data[p*32 +: 32] !== exp_data(rd_addr[p*5 +: 5]) ||
            rd_busy[p] !== exp_busy(rd_addr[p*5 +: 5]))
          $display("FAIL random_read cyc %0d port %0d addr %0d: got %h/%b, want %h/%b",
                   c, p, rd_addr[p*5 +: 5], rd_data[p*32 +: 32], rd_busy[p],
                   exp_data(rd_addr[p*5 +: 5]), exp_busy(rd_addr[p*5 +: 5]));
        else n_pass++;
      end
      n_checks++;
      if (clear_busy !== (m_clr_left > 0) || clear_done !== m_done)
        $display("FAIL random_clear_flags cyc %0d: got %b/%b, want %b/%b",
                 c, clear_busy, clear_done, (m_clr_left > 0), m_done);
      else n_pass++;
      tick();
    end
    idle_inputs();
    wait_idle();
  endtask

  task automatic test_clear();
    int busy_cycles;
    int done_cnt;
    busy_cycles = 0;
    done_cnt    = 0;
    wr_ena = 1'b1;
    for (int i = 1; i < NREGS; i++) begin
      wr_addr = 5'(i);
      wr_data = 32'h100 + 32'(i);
      tick();
    end
    wr_ena = 1'b0; claim_ena = 1'b1; claim_addr = 5'd3;
    tick();
    claim_ena = 1'b0; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 40; k++) begin
      wr_ena  = (k == 5);
      wr_addr = 5'd4;
      wr_data = 32'hBAD0BAD0;
      rd_addr = {m_clr_idx[4:0], 5'd4};
      #1;
      if (clear_busy) busy_cycles++;
      if (clear_done) done_cnt++;
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (rd_data[p*32 +: 32] !== exp_data(rd_addr[p*5 +: 5]))
          $display("FAIL clear_read k %0d port %0d: got %h, want %h",
                   k, p, rd_data[p*32 +: 32], exp_data(rd_addr[p*5 +: 5]));
        else n_pass++;
      end
      n_checks++;
      if (clear_busy !== (m_clr_left > 0) || clear_done !== m_done)
        $display("FAIL clear_flags k %0d: got %b/%b, want %b/%b",
                 k, clear_busy, clear_done, (m_clr_left > 0), m_done);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (busy_cycles !== 31) $display("FAIL clear_duration: got %0d, want 31", busy_cycles);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1) $display("FAIL clear_done_pulses: got %0d, want 1", done_cnt);
    else n_pass++;
    idle_inputs();
    for (int a = 0; a < NREGS; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      n_checks++;
      if (rd_data !== 64'd0 || rd_busy !== 2'b00)
        $display("FAIL after_clear addr %0d: got %h/%b, want 0/00", a, rd_data, rd_busy);
      else n_pass++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic seen;
    seen = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (clear_done) begin
        seen = 1'b1;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n_checks++;
        if (clear_busy !== 1'b1)
          $display("FAIL b2b_clear_accept: got busy %b, want 1", clear_busy);
        else n_pass++;
      end else begin
        tick();
      end
    end
    n_checks++;
    if (seen !== 1'b1) $display("FAIL b2b_done_seen: got %b, want 1", seen);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_reset_mid_clear();
    int done_cnt;
    done_cnt = 0;
    wr_ena = 1'b1; wr_addr = 5'd30; wr_data = 32'h77;
    tick();
    wr_ena = 1'b0; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (clear_busy !== 1'b0 || clear_done !== 1'b0)
      $display("FAIL reset_mid_clear: got busy %b done %b, want 0/0", clear_busy, clear_done);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b1;
    rd_addr = {5'd30, 5'd30};
    #1;
    n_checks++;
    if (rd_data !== 64'd0) $display("FAIL reset_mid_clear_data: got %h, want 0", rd_data);
    else n_pass++;
    for (int k = 0; k < 40; k++) begin
      if (clear_done || clear_busy) done_cnt++;
      tick();
    end
    n_checks++;
    if (done_cnt !== 0) $display("FAIL reset_mid_clear_no_done: got %0d, want 0", done_cnt);
    else n_pass++;
  endtask

  task automatic test_small_config();
    int busy_cycles;
    int done_cnt;
    busy_cycles = 0;
    done_cnt    = 0;
    s_wr_ena = 1'b1; s_wr_addr = 3'd0; s_wr_data = 8'hA5; s_rd_addr = 9'd0;
    #1;
    n_checks++;
    if (s_rd_data !== 24'hA5A5A5) $display("FAIL small_bypass: got %h, want a5a5a5", s_rd_data);
    else n_pass++;
    tick();
    s_wr_ena = 1'b0; s_claim_ena = 1'b1; s_claim_addr = 3'd2;
    #1;
    n_checks++;
    if (s_rd_data !== 24'hA5A5A5 || s_rd_busy !== 3'b000)
      $display("FAIL small_stored: got %h/%b, want a5a5a5/000", s_rd_data, s_rd_busy);
    else n_pass++;
    tick();
    s_claim_ena = 1'b0;
    s_rd_addr = {3'd0, 3'd2, 3'd0};
    #1;
    n_checks++;
    if (s_rd_busy !== 3'b010) $display("FAIL small_claim: got %b, want 010", s_rd_busy);
    else n_pass++;
    s_clear_req = 1'b1;
    tick();
    s_clear_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (s_clear_busy) busy_cycles++;
      if (s_clear_done) done_cnt++;
      tick();
    end
    n_checks++;
    if (busy_cycles !== 8) $display("FAIL small_clear_duration: got %0d, want 8", busy_cycles);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1) $display("FAIL small_clear_done: got %0d, want 1", done_cnt);
    else n_pass++;
    n_checks++;
    if (s_rd_data !== 24'd0 || s_rd_busy !== 3'b000)
      $display("FAIL small_after_clear: got %h/%b, want 0/000", s_rd_data, s_rd_busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_claim();
    test_random();
    test_clear();
    test_back_to_back();
    test_reset_mid_clear();
    test_small_config();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
